cnu_msg_expand: RTL and testbench

//   Serial expander at the output end of the check-node unit.

---
 rtl/cnu_msg_expand.sv | 115 +++++++++++
 tb/tb_cnu_msg_expand.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cnu_msg_expand.sv
// Serial check-to-variable message expander: one compressed min-sum record in, DEG sign-magnitude edges out.
// Optional offset min-sum is enabled with the CNU_OFFSET_EN macro.
module cnu_msg_expand #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 8,
   parameter int DEG    = 6,
   parameter int OFFSET = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_min1,
   input  logic [DATA_W-1:0] in_min2,
   input  logic [IDX_W-1:0]  in_idx,
   input  logic [DEG-1:0]    in_sign,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W:0]   out_msg,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last
);

   typedef enum logic {IDLE, EXPAND} state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEG - 1);

`ifdef CNU_OFFSET_EN
   localparam logic [DATA_W:0] EFF_OFF = (DATA_W + 1)'(OFFSET);
`else
   // Plain min-sum: the subtract below degenerates to a pass-through.
   localparam logic [DATA_W:0] EFF_OFF = (DATA_W + 1)'(0 * OFFSET);
`endif

   state_t            state;
   logic [IDX_W-1:0]  cnt;
   logic [DATA_W-1:0] min1_q;
   logic [DATA_W-1:0] min2_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DEG-1:0]    sign_q;
   logic              tsign_q;

   // Message for edge e: the other edges' minimum, the product of the other edges' signs, no negative zero.
   function automatic logic [DATA_W:0] edge_msg(
      input logic [IDX_W-1:0]  e,
      input logic [DATA_W-1:0] m1,
      input logic [DATA_W-1:0] m2,
      input logic [IDX_W-1:0]  id,
      input logic [DEG-1:0]    sg,
      input logic              ts
   );
      logic [DATA_W-1:0] sel;
      logic [DATA_W:0]   diff;
      logic [DATA_W-1:0] mag;
      logic [DEG-1:0]    sh;
      logic              sgn;
      sel  = (e == id) ? m2 : m1;
      diff = {1'b0, sel} - EFF_OFF;
      mag  = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
      sh   = sg >> e;
      sgn  = (ts ^ sh[0]) & (mag != '0);
      return {sgn, mag};
   endfunction

   assign in_ready = (state == IDLE);
   assign out_idx  = cnt;

   // NOTE: every register here, record latches included, is cleared by reset so a discarded record leaves no trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         min1_q    <= '0;
         min2_q    <= '0;
         idx_q     <= '0;
         sign_q    <= '0;
         tsign_q   <= 1'b0;
         out_valid <= 1'b0;
         out_msg   <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  min1_q    <= in_min1;
                  min2_q    <= in_min2;
                  idx_q     <= in_idx;
                  sign_q    <= in_sign;
                  tsign_q   <= ^in_sign;
                  cnt       <= '0;
                  state     <= EXPAND;
                  out_valid <= 1'b1;
                  out_last  <= (LAST == '0);
                  out_msg   <= edge_msg('0, in_min1, in_min2, in_idx, in_sign, ^in_sign);
               end
            end
            EXPAND: begin
               if (out_ready) begin
                  if (cnt == LAST) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     cnt      <= cnt + 1'b1;
                     out_last <= ((cnt + 1'b1) == LAST);
                     out_msg  <= edge_msg(cnt + 1'b1, min1_q, min2_q, idx_q, sign_q, tsign_q);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnu_msg_expand.sv
// Directed self-checking bench for cnu_msg_expand (DEG=6, DATA_W=8, IDX_W=8, OFFSET=1).
// Expected vectors switch with CNU_OFFSET_EN to match the build under test.
module tb_cnu_msg_expand;

   typedef logic [8:0] vec_t [6];

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_min1;
   logic [7:0] in_min2;
   logic [7:0] in_idx;
   logic [5:0] in_sign;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_msg;
   logic [7:0] out_idx;
   logic       out_last;

   int n_cmp = 0;
   int n_err = 0;

   cnu_msg_expand #(.DATA_W(8), .IDX_W(8), .DEG(6), .OFFSET(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_min1(in_min1), .in_min2(in_min2), .in_idx(in_idx), .in_sign(in_sign),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_msg(out_msg), .out_idx(out_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] m1, input logic [7:0] m2,
                       input logic [7:0] id, input logic [5:0] sg);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_min1  = m1;
      in_min2  = m2;
      in_idx   = id;
      in_sign  = sg;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_min1  = 8'hee;
      in_min2  = 8'hdd;
      in_idx   = 8'h01;
      in_sign  = 6'h3f;
   endtask

   // Checks beats 0..last_k; optionally stalls stall_n cycles on beat stall_k.
   task automatic expect_beats(input vec_t exp, input int last_k,
                               input int stall_k, input int stall_n);
      for (int k = 0; k <= last_k; k++) begin
         check($sformatf("valid_e%0d", k), 32'(out_valid), 32'd1);
         check($sformatf("idx_e%0d", k), 32'(out_idx), 32'(k));
         check($sformatf("msg_e%0d", k), 32'(out_msg), 32'(exp[k]));
         check($sformatf("last_e%0d", k), 32'(out_last), 32'(k == 5));
         check($sformatf("in_ready_busy_e%0d", k), 32'(in_ready), 32'd0);
         if (k == stall_k) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_n; s++) begin
               tick();
               check($sformatf("stall%0d_valid", s), 32'(out_valid), 32'd1);
               check($sformatf("stall%0d_idx", s), 32'(out_idx), 32'(k));
               check($sformatf("stall%0d_msg", s), 32'(out_msg), 32'(exp[k]));
               check($sformatf("stall%0d_last", s), 32'(out_last), 32'(k == 5));
               check($sformatf("stall%0d_in_ready", s), 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
         end
         tick();
      end
      if (last_k == 5) begin
         check("bubble_valid", 32'(out_valid), 32'd0);
         check("bubble_in_ready", 32'(in_ready), 32'd1);
      end
   endtask

   vec_t e1, e2, e4, e6;

   initial begin
`ifdef CNU_OFFSET_EN
      e1 = '{9'h002, 9'h002, 9'h006, 9'h002, 9'h002, 9'h002};
      e2 = '{9'h108, 9'h003, 9'h103, 9'h003, 9'h003, 9'h003};
      e4 = '{9'h004, 9'h004, 9'h004, 9'h004, 9'h004, 9'h004};
      e6 = '{9'h000, 9'h000, 9'h000, 9'h003, 9'h000, 9'h000};
`else
      e1 = '{9'h003, 9'h003, 9'h007, 9'h003, 9'h003, 9'h003};
      e2 = '{9'h109, 9'h004, 9'h104, 9'h004, 9'h004, 9'h004};
      e4 = '{9'h005, 9'h005, 9'h005, 9'h005, 9'h005, 9'h005};
      e6 = '{9'h101, 9'h101, 9'h001, 9'h004, 9'h001, 9'h001};
`endif
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_min1   = '0;
      in_min2   = '0;
      in_idx    = '0;
      in_sign   = '0;
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_msg", 32'(out_msg), 32'd0);
      check("rst_out_idx", 32'(out_idx), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Plain record, min2 on the min1 edge.
      send(8'd3, 8'd7, 8'd2, 6'b000000);
      expect_beats(e1, 5, -1, 0);

      // Signs: edges 0 and 2 negative, min1 at edge 0.
      send(8'd4, 8'd9, 8'd0, 6'b000101);
      expect_beats(e2, 5, -1, 0);

      // Backpressure on burst cycles 2-4 holds edge 1.
      send(8'd3, 8'd7, 8'd2, 6'b000000);
      expect_beats(e1, 5, 1, 3);

      // Out-of-range index: every edge gets min1.
      send(8'd5, 8'd6, 8'd9, 6'b000000);
      expect_beats(e4, 5, -1, 0);

      // Reset after edge 2 is consumed.
      send(8'd4, 8'd9, 8'd0, 6'b000101);
      expect_beats(e2, 2, -1, 0);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_idx", 32'(out_idx), 32'd0);
      check("midrst_out_last", 32'(out_last), 32'd0);
      check("midrst_out_msg", 32'(out_msg), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd0);
      send(8'd4, 8'd9, 8'd0, 6'b000101);
      expect_beats(e2, 5, -1, 0);

      // Zero-magnitude edges under offset; plain min-sum otherwise.
      send(8'd1, 8'd4, 8'd3, 6'b000011);
      expect_beats(e6, 5, -1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
